resp_uart_tx: RTL and testbench
===============================

# resp_uart_tx

Outbound half of the host UART link. It takes a 16-bit read-response word from the bus side and serialises it to the host as an ASCII frame. The frame is `M` + 4 uppercase hex digits + CR + LF, sent as 8N1 UART bytes. The block sits between the memory/register bridge read path and the `tx` pin, mirroring the request decoder on the `rx` pin.

## Interface
Parameters:
- CLOCKS_PER_BAUD, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  16  read-response word to report.
- valid_i  input  1  data_i holds a word to send.
- ready_o  output  1  block can accept a word; transfer occurs when valid_i && ready_o on a rising edge.
- tx  output  1  UART serial out; idles high.
- busy_o  output  1  a frame is in progress (equals !ready_o).

## Operation
- Reset values: tx=1, ready_o=1, busy_o=0; FSM in IDLE; byte index 0; baud counter 0.
- On acceptance, data_i is latched; later changes to data_i or valid_i are ignored until the next IDLE.
- Frame bytes, in order (index 0..6):
  - 0x4D ('M')
  - hex(data[15:12]), hex(data[11:8]), hex(data[7:4]), hex(data[3:0])
  - 0x0D, 0x0A
- Hex encoding: nibble 0–9 maps to 0x30–0x39; nibble A–F maps to 0x41–0x46.
- Each byte is sent as one start bit (0), eight data bits LSB first, then one stop bit (1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on acceptance.
  - START → DATA after CLOCKS_PER_BAUD cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if byte index < 6; the index increments.
  - STOP → IDLE after the stop bit of byte 6.
- Baud counter counts 0..CLOCKS_PER_BAUD-1 and wraps at each bit boundary. Bit counter is 3 bits wide; byte index is 3 bits wide.
- ready_o is a registered decode of state == IDLE.
- Reset mid-frame: tx goes to 1 immediately (asynchronously) and the latched word is discarded. No partial frame is resumed after rst_n deasserts.

## Timing
- The acceptance edge is cycle 0. tx falls to 0 at cycle 1, i.e. one registered-output cycle of latency.
- Every bit, including start, parity (when enabled) and stop, lasts exactly CLOCKS_PER_BAUD cycles.
- Bits per byte B: 10 in the base build, 11 with parity.
- Full frame length is 7·B·CLOCKS_PER_BAUD cycles. IDLE, and therefore ready_o=1, is re-entered on the cycle after the last stop bit.
- Bytes are back-to-back: no idle time between the stop bit of one byte and the start bit of the next.
- If valid_i is held high, the next word is accepted on the first IDLE cycle. This leaves exactly one extra idle-high cycle on tx between frames.

## Configuration
- RESP_UART_TX_PARITY_EN:
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted between bit 7 and the stop bit, and the FSM adds a PARITY state between DATA and STOP. B = 11.
  - Undefined: no parity state and B = 10. This is the default, matching the host's 8N1 setting.

## Test plan
- CLOCKS_PER_BAUD=4; accept 0xBEEF; sample tx mid-bit:
  - decoded bytes are 4D 42 45 45 46 0D 0A;
  - the frame lasts 280 cycles;
  - ready_o returns to 1 at cycle 281.
- Accept 0x0000, then 0xA5F9 with valid_i held high:
  - frames decode to `M0000\r\n` then `MA5F9\r\n`;
  - exactly one idle-high cycle separates the two frames.
- Change data_i to 0x1234 at cycle 10 of a 0xBEEF frame: the transmitted frame is still `MBEEF\r\n`, and valid_i is ignored while busy_o=1.
- Assert rst_n=0 mid-DATA of byte 3:
  - tx=1 and ready_o=1 with no clock edge;
  - after release, tx stays high until a new valid_i;
  - the next frame is complete and correct.
- With RESP_UART_TX_PARITY_EN defined, accept 0x1000:
  - the 'M' parity bit is 0 (four ones) and the '1' (0x31) parity bit is 1;
  - the frame lasts 7·11·CLOCKS_PER_BAUD cycles.
- CLOCKS_PER_BAUD=2 corner: bit widths are exactly 2 cycles and no counter wrap glitch occurs on tx.

Source files
------------

// File: rtl/resp_uart_tx.sv
// resp_uart_tx
//   Outbound half of the host UART link. A 16-bit read-response word is
//   accepted from the bus side and sent to the host as the ASCII frame
//   'M' + four uppercase hex digits + CR + LF, each byte framed 8N1
//   (start bit, eight data bits LSB first, stop bit).
//
//   Optional feature macro: RESP_UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the eight data bits) is sent
//     between data bit 7 and the stop bit, using an extra PARITY state.
//     When undefined (default), bytes are plain 8N1.
//
// Parameters
//   CLOCKS_PER_BAUD : clock cycles per UART bit (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   data_i   in   read-response word to report
//   valid_i  in   data_i holds a word to send
//   ready_o  out  block can accept a word (transfer on valid_i && ready_o)
//   tx       out  UART serial output, idles high
//   busy_o   out  frame in progress (always !ready_o)

module resp_uart_tx #(
  parameter int CLOCKS_PER_BAUD = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        tx,
  output logic        busy_o
);

  localparam int                BAUD_W    = (CLOCKS_PER_BAUD > 2) ? $clog2(CLOCKS_PER_BAUD) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [2:0]        LAST_BYTE = 3'd6;
  localparam logic [2:0]        LAST_BIT  = 3'd7;

`ifdef RESP_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_cnt, bit_next;
  logic [2:0]        byte_idx, byte_next;
  logic [15:0]       word_q, word_next;
  logic              tx_q, tx_next;
  logic              ready_q, ready_next;
  logic [7:0]        cur_byte;
  logic              bit_done;

  // ASCII for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (8'h30 + wide) : (8'h37 + wide);
  endfunction

  // Byte at a given position of the frame for the latched word
  function automatic logic [7:0] frame_byte(input logic [15:0] word, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h4D;
      3'd1:    b = hex_ascii(word[15:12]);
      3'd2:    b = hex_ascii(word[11:8]);
      3'd3:    b = hex_ascii(word[7:4]);
      3'd4:    b = hex_ascii(word[3:0]);
      3'd5:    b = 8'h0D;
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  assign bit_done = (baud_cnt == BAUD_LAST);

  // State register. tx and ready_o are flopped from the next-state decode,
  // so both are glitch-free and change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      word_q   <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      byte_idx <= byte_next;
      word_q   <= word_next;
      tx_q     <= tx_next;
      ready_q  <= ready_next;
    end
  end

  // Next-state logic. The baud counter wraps to zero at every bit boundary,
  // and bytes chain directly from STOP into the next START.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    byte_next  = byte_idx;
    word_next  = word_q;
    case (state)
      IDLE: begin
        if (valid_i && ready_q) begin
          state_next = START;
          word_next  = data_i;
          baud_next  = '0;
          bit_next   = '0;
          byte_next  = '0;
        end
      end
      START: begin
        if (bit_done) begin
          state_next = DATA;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == LAST_BIT) begin
            bit_next = '0;
`ifdef RESP_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
`ifdef RESP_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_next = STOP;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          baud_next = '0;
          if (byte_idx < LAST_BYTE) begin
            state_next = START;
            byte_next  = byte_idx + 3'd1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
        byte_next  = '0;
      end
    endcase
  end

  // Output decode from the next state, registered above
  always_comb begin
    tx_next    = 1'b1;
    cur_byte   = frame_byte(word_next, byte_next);
    ready_next = (state_next == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_next];
`ifdef RESP_UART_TX_PARITY_EN
      PARITY:  tx_next = ^cur_byte;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = !ready_q;

endmodule

// File: tb/tb_resp_uart_tx.sv
// tb_resp_uart_tx
//   Drives two resp_uart_tx instances (CLOCKS_PER_BAUD = 4 and 2) from the
//   same inputs. A frame-level model per instance predicts tx / ready_o /
//   busy_o every cycle; directed sections decode the transmitted bytes of
//   the CLOCKS_PER_BAUD = 4 instance and compare against hand-written
//   ASCII literals.

module tb_resp_uart_tx;

`ifdef RESP_UART_TX_PARITY_EN
  localparam int B = 11;
  localparam int FRAME0 = 308;
`else
  localparam int B = 10;
  localparam int FRAME0 = 280;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic [1:0]  tx_v, ready_v, busy_v;
  logic        check_en = 1'b0;

  int checks = 0;
  int failures = 0;

  logic       samp [0:1023];
  logic [7:0] lit [0:6];

  always #5 clk = ~clk;

  resp_uart_tx #(.CLOCKS_PER_BAUD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_v[0]), .tx(tx_v[0]), .busy_o(busy_v[0])
  );

  resp_uart_tx #(.CLOCKS_PER_BAUD(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_v[1]), .tx(tx_v[1]), .busy_o(busy_v[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ASCII byte k of the frame for word w
  function automatic logic [7:0] exp_byte(input logic [15:0] w, input int k);
    logic [3:0] n;
    case (k)
      0: return 8'h4D;
      5: return 8'h0D;
      6: return 8'h0A;
      default: begin
        n = 4'((w >> (4 * (4 - k))) & 16'hF);
        if (n < 4'd10) return 8'h30 + 8'(n);
        else return 8'h41 + 8'(n - 4'd10);
      end
    endcase
  endfunction

  // Whole frame as a bit sequence in transmit order
  function automatic logic [76:0] frame_vec(input logic [15:0] w);
    logic [76:0] v;
    logic [7:0]  b;
    v = '1;
    for (int k = 0; k < 7; k++) begin
      b = exp_byte(w, k);
      v[k*B] = 1'b0;
      for (int j = 0; j < 8; j++) v[k*B+1+j] = b[j];
`ifdef RESP_UART_TX_PARITY_EN
      v[k*B+9] = ^b;
`endif
      v[k*B+B-1] = 1'b1;
    end
    return v;
  endfunction

  // Byte k of a captured frame starting at samp[base], sampled mid-bit
  function automatic logic [7:0] decode_byte(input int base, input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = samp[base + (k*B + 1 + j)*4 + 2];
    return b;
  endfunction

  // Per-instance model: a frame is a list of bits each held CPB cycles
  for (genvar k = 0; k < 2; k++) begin : g_chk
    localparam int CPB = (k == 0) ? 4 : 2;
    localparam int TOTAL = 7 * B * CPB;
    logic        m_busy;
    int          m_pos;
    logic [76:0] m_bits;
    logic        m_tx;
    logic        m_ready;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy  <= 1'b0;
        m_pos   <= 0;
        m_bits  <= '1;
        m_tx    <= 1'b1;
        m_ready <= 1'b1;
      end else if (m_busy) begin
        if (m_pos + 1 == TOTAL) begin
          m_busy  <= 1'b0;
          m_tx    <= 1'b1;
          m_ready <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
          m_tx  <= m_bits[(m_pos + 1) / CPB];
        end
      end else if (valid_i) begin
        m_busy  <= 1'b1;
        m_pos   <= 0;
        m_bits  <= frame_vec(data_i);
        m_tx    <= 1'b0;
        m_ready <= 1'b0;
      end
    end

    always @(negedge clk) begin
      if (rst_n && check_en) begin
        checkOutput($sformatf("tx_cpb%0d", CPB), int'(tx_v[k]), int'(m_tx));
        checkOutput($sformatf("ready_cpb%0d", CPB), int'(ready_v[k]), int'(m_ready));
        checkOutput($sformatf("busy_cpb%0d", CPB), int'(busy_v[k]), int'(!m_ready));
      end
    end
  end

  // Present a word for one acceptance edge; optionally leave valid_i high
  task automatic applyStimulus(input logic [15:0] w, input bit hold);
    @(negedge clk);
    data_i  = w;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_i = 1'b0;
  endtask

  // Record tx of instance 0 for ncyc cycles after an acceptance edge
  task automatic captureFrame(input int ncyc, input int change_at, input logic [15:0] new_data,
                              input int drop_at, output int busy_cycles, output int first_ready);
    busy_cycles = 0;
    first_ready = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      samp[n-1] = tx_v[0];
      if (!ready_v[0]) busy_cycles++;
      if (ready_v[0] && first_ready == 0) first_ready = n;
      if (n == change_at) begin
        data_i  = new_data;
        valid_i = 1'b1;
      end
      if (n == drop_at) valid_i = 1'b0;
    end
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 2000 && ready_v != 2'b11; i++) @(negedge clk);
    checkOutput("idle_wait", int'(ready_v), 3);
  endtask

  task automatic checkFrame(input string tag, input int base, input logic [15:0] w);
    for (int k = 0; k < 7; k++)
      checkOutput($sformatf("%s_byte%0d", tag, k), int'(decode_byte(base, k)), int'(lit[k]));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cycles, first_ready, gap, idx, highs;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_tx", int'(tx_v[0]), 1);
    checkOutput("reset_ready", int'(ready_v[0]), 1);
    checkOutput("reset_busy", int'(busy_v[0]), 0);
    rst_n = 1'b1;
    check_en = 1'b1;
    repeat (2) @(negedge clk);

    // 0xBEEF, data_i and valid_i disturbed mid-frame
    $display("[TB] frame 0xBEEF with data change at cycle 10");
    applyStimulus(16'hBEEF, 1'b0);
    captureFrame(FRAME0 + 20, 10, 16'h1234, 100, busy_cycles, first_ready);
    lit = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    checkFrame("beef", 0, 16'hBEEF);
    checkOutput("beef_frame_len", busy_cycles, FRAME0);
    checkOutput("beef_ready_cycle", first_ready, FRAME0 + 1);
    checkOutput("beef_start_bit", int'(samp[2]), 0);
    checkOutput("beef_stop_bit", int'(samp[FRAME0 - 1]), 1);
    waitIdle();

    // 0x0000 then 0xA5F9 with valid_i held high
    $display("[TB] back-to-back frames 0x0000 / 0xA5F9");
    applyStimulus(16'h0000, 1'b1);
    data_i = 16'hA5F9;
    captureFrame(2 * FRAME0 + 20, 0, 16'h0000, FRAME0 + 2, busy_cycles, first_ready);
    lit = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    checkFrame("zero", 0, 16'h0000);
    lit = '{8'h4D, 8'h41, 8'h35, 8'h46, 8'h39, 8'h0D, 8'h0A};
    checkFrame("a5f9", FRAME0 + 1, 16'hA5F9);
    gap = 0;
    idx = FRAME0;
    while (idx < 1000 && samp[idx] == 1'b1) begin
      gap++;
      idx++;
    end
    checkOutput("idle_gap", gap, 1);
    waitIdle();

    // Reset in the middle of byte 3's data bits
    $display("[TB] reset mid-frame");
    applyStimulus(16'h3C5A, 1'b0);
    repeat (139) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", int'(tx_v[0]), 1);
    checkOutput("async_reset_ready", int'(ready_v[0]), 1);
    checkOutput("async_reset_busy", int'(busy_v[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0]) highs++;
    end
    checkOutput("tx_idle_after_reset", highs, 20);
    applyStimulus(16'h7E01, 1'b0);
    captureFrame(FRAME0 + 10, 0, 16'h0000, 0, busy_cycles, first_ready);
    lit = '{8'h4D, 8'h37, 8'h45, 8'h30, 8'h31, 8'h0D, 8'h0A};
    checkFrame("post_reset", 0, 16'h7E01);
    checkOutput("post_reset_len", busy_cycles, FRAME0);
    waitIdle();

`ifdef RESP_UART_TX_PARITY_EN
    $display("[TB] parity frame 0x1000");
    applyStimulus(16'h1000, 1'b0);
    captureFrame(FRAME0 + 10, 0, 16'h0000, 0, busy_cycles, first_ready);
    checkOutput("parity_M", int'(samp[9*4 + 2]), 0);
    checkOutput("parity_1", int'(samp[(B + 9)*4 + 2]), 1);
    checkOutput("parity_len", busy_cycles, 7 * 11 * 4);
    waitIdle();
`endif

    // Randomized traffic, checked every cycle by the model
    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid_i = ($urandom_range(0, 7) == 0);
      data_i  = 16'($urandom);
    end
    @(negedge clk);
    valid_i = 1'b0;
    waitIdle();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
